// File: rtl/framing_overlap_pkg.sv
// Shared definitions for the overlapped framer.
//   - Default widths and frame geometry used as parameter defaults by the top.
//   - FSM state encoding for the frame read sequencer.
package framing_overlap_pkg;

  localparam int DEF_I_BW      = 9;
  localparam int DEF_O_BW      = 16;
  localparam int DEF_FRAME_LEN = 256;
  localparam int DEF_HOP       = 128;
  localparam int DEF_BUF_DEPTH = 512;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } frm_state_e;

endpackage

// File: rtl/framing_overlap_buf.sv
// Circular sample store for the framer.
//   clk_i            clock
//   wr_en/addr/data  write port, one sample per cycle
//   rd_en/addr       read request
//   rd_data          registered read data, valid the cycle after rd_en
// Contents are never reset; the framer only reads entries it has written.
module framing_overlap_buf #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 512,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     rd_en,
  input  logic [AW-1:0]            rd_addr,
  output logic signed [DATA_W-1:0] rd_data
);

  logic signed [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk_i) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/framing_overlap.sv
// Overlapped framer: cuts a continuous sample stream into frames of
// FRAME_LEN samples whose starts are HOP samples apart.
//   clk_i       clock
//   rst_n_i     synchronous active-low reset
//   en_i        enable; low clears the framer like a reset
//   data_i      signed input sample, valid_i strobe (no input backpressure)
//   data_o      sign-extended frame sample, valid_o / ready_i handshake
//   last_o      marks the final sample of each frame
//   overflow_o  sticky: an input sample was dropped
module framing_overlap
  import framing_overlap_pkg::*;
#(
  parameter int I_BW      = DEF_I_BW,
  parameter int O_BW      = DEF_O_BW,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int HOP       = DEF_HOP,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   en_i,
  input  logic signed [I_BW-1:0] data_i,
  input  logic                   valid_i,
  output logic signed [O_BW-1:0] data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   last_o,
  output logic                   overflow_o
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int FW = $clog2(BUF_DEPTH + 1);
  localparam int EW = $clog2(FRAME_LEN + 1);

  function automatic logic signed [O_BW-1:0] sext(input logic signed [I_BW-1:0] s);
    return O_BW'(s);
  endfunction

  logic                   clr;
  frm_state_e             state_q, state_d;
  logic [AW-1:0]          wr_ptr_q, base_ptr_q, rd_addr;
  logic [FW-1:0]          fill_q, fill_d;
  logic [EW-1:0]          elem_q, elem_d;
  logic                   ovf_q;
  logic                   wr_en, drop, rd_en, rd_last, room;
  logic                   hs, pop, push, frame_end;
  logic                   valid_int, head_last;
  logic signed [I_BW-1:0] head_data;
  logic [1:0]             occ;

  logic                   vld_p1, last_p1;
  logic signed [I_BW-1:0] rdata_p1;

  logic [1:0]             skid_cnt_p2;
  logic                   skid_rd_p2, skid_wr_p2;
  logic signed [I_BW-1:0] skid_data_p2 [2];
  logic                   skid_last_p2 [2];

  assign clr = !rst_n_i || !en_i;

  // ---- stage p0: buffer write, read issue ----
  // A frame end in the same cycle frees the slot at base_ptr, so a sample
  // arriving with a full buffer is still taken in that cycle.
  assign wr_en = !clr && valid_i && ((fill_q < FW'(BUF_DEPTH)) || frame_end);
  assign drop  = valid_i && !wr_en;

  // Reads in flight plus skid entries never exceed the two skid slots.
  assign occ  = skid_cnt_p2 + 2'(vld_p1);
  assign room = occ < 2'd2;

  assign rd_addr = base_ptr_q + AW'(elem_q);
  assign rd_last = (elem_q == EW'(FRAME_LEN - 1));

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    rd_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fill_q >= FW'(FRAME_LEN)) begin
          rd_en   = 1'b1;
          elem_d  = EW'(1);
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if ((elem_q < EW'(FRAME_LEN)) && room) begin
          rd_en  = 1'b1;
          elem_d = elem_q + EW'(1);
        end
        if (frame_end) begin
          elem_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fill_d = fill_q + FW'(wr_en);
    if (frame_end) fill_d = fill_d - FW'(HOP);
  end

  framing_overlap_buf #(
    .DATA_W (I_BW),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk_i   (clk_i),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (data_i),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rdata_p1)
  );

  // ---- stage p1: read data returns; bypasses the skid when it is empty ----
  assign valid_int = (skid_cnt_p2 != 2'd0) || vld_p1;
  assign head_data = (skid_cnt_p2 != 2'd0) ? skid_data_p2[skid_rd_p2] : rdata_p1;
  assign head_last = (skid_cnt_p2 != 2'd0) ? skid_last_p2[skid_rd_p2] : last_p1;
  assign hs        = valid_int && ready_i;
  assign frame_end = hs && head_last;
  assign pop       = hs && (skid_cnt_p2 != 2'd0);
  assign push      = vld_p1 && !((skid_cnt_p2 == 2'd0) && ready_i);

  // ---- stage p2: skid buffer and outputs ----
  assign valid_o    = valid_int;
  assign last_o     = valid_int && head_last;
  assign data_o     = valid_int ? sext(head_data) : '0;
  assign overflow_o = ovf_q;

  always_ff @(posedge clk_i) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      base_ptr_q  <= '0;
      fill_q      <= '0;
      elem_q      <= '0;
      ovf_q       <= 1'b0;
      vld_p1      <= 1'b0;
      skid_cnt_p2 <= 2'd0;
      skid_rd_p2  <= 1'b0;
      skid_wr_p2  <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      fill_q  <= fill_d;
      vld_p1  <= rd_en;
      if (wr_en)     wr_ptr_q   <= wr_ptr_q + AW'(1);
      if (frame_end) base_ptr_q <= base_ptr_q + AW'(HOP);
      if (drop)      ovf_q      <= 1'b1;
      skid_cnt_p2 <= skid_cnt_p2 + 2'(push) - 2'(pop);
      if (push) skid_wr_p2 <= ~skid_wr_p2;
      if (pop)  skid_rd_p2 <= ~skid_rd_p2;
    end
  end

  always_ff @(posedge clk_i) begin
    last_p1 <= rd_last;
    if (push) begin
      skid_data_p2[skid_wr_p2] <= rdata_p1;
      skid_last_p2[skid_wr_p2] <= last_p1;
    end
  end

endmodule
